prog_delay_line: RTL

Runtime-programmable, multi-bit transmission-line delay model for the TDR fault-detector fabric. It delays a valid-qualified sample stream by D samples, with D loaded at run time (1..MAX_DELAY), using a circular sample buffer. Output stays invalid until the line has refilled after reset or a delay change. It sits between the stimulus generator and the reflection/echo path, so a cable length can be swept without resynthesis.

---
 rtl/tdr_pkg.sv | 19 +
 rtl/prog_delay_line_if.sv | 29 ++
 rtl/prog_delay_line_sample_ram.sv | 25 ++
 rtl/prog_delay_line.sv | 109 ++++++++++
 4 files changed

// File: rtl/tdr_pkg.sv
// Shared types and helpers for the TDR delay-line model.
// Imported by the delay line top level.
package tdr_pkg;

  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } dline_state_e;

  function automatic int unsigned clamp_delay(
    input int unsigned d,
    input int unsigned max_d
  );
    if (d == 0) return 1;
    if (d > max_d) return max_d;
    return d;
  endfunction

endpackage

// File: rtl/prog_delay_line_if.sv
// Sample stream and delay-config bundle for the delay line.
// master drives stimulus and config, slave is the delay line.
interface prog_delay_line_if #(
  parameter int WIDTH = 8,
  parameter int DLY_W = 9
);
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             cfg_load;
  logic [DLY_W-1:0] delay_cfg;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             filling;
  logic [DLY_W-1:0] cur_delay;

  modport master (
    output in_valid, in_data,
    output cfg_load, delay_cfg,
    input  out_valid, out_data,
    input  filling, cur_delay
  );

  modport slave (
    input  in_valid, in_data,
    input  cfg_load, delay_cfg,
    output out_valid, out_data,
    output filling, cur_delay
  );
endinterface

// File: rtl/prog_delay_line_sample_ram.sv
// Simple dual-port sample buffer, read-first on address collision.
// No reset so it maps onto block RAM.
module sample_ram #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_re,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk) begin
    if (i_re) r_q <= r_mem[i_raddr];
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_q;
endmodule

// File: rtl/prog_delay_line.sv
// Runtime-programmable sample delay line over a circular buffer.
// Output is gated until D fresh samples have been written.
module prog_delay_line
  import tdr_pkg::*;
#(
  parameter int WIDTH         = 8,
  parameter int MAX_DELAY     = 256,
  parameter int DEFAULT_DELAY = 64,
  parameter int DLY_W         = $clog2(MAX_DELAY + 1)
) (
  input logic              clk,
  input logic              rst,
  prog_delay_line_if.slave bus
);
  localparam int PTR_W = $clog2(MAX_DELAY);
  localparam int SW    = DLY_W + 1;

  dline_state_e     r_state, w_state_nx;
  logic [DLY_W-1:0] r_fill_cnt, w_fill_nx;
  logic [DLY_W-1:0] r_cur_delay, w_cur_nx;
  logic [PTR_W-1:0] r_wr_ptr, w_wr_nx;
  logic [PTR_W-1:0] w_rd_ptr;
  logic [SW-1:0]    w_sum;
  logic             r_out_valid, w_ov_nx;
  logic             r_out_sel, w_sel_nx;
  logic [WIDTH-1:0] w_ram_q;

  // wr_ptr - D mod MAX_DELAY without a divider
  assign w_sum = SW'(r_wr_ptr) + SW'(MAX_DELAY)
               - SW'(r_cur_delay);
  assign w_rd_ptr = (w_sum >= SW'(MAX_DELAY))
                  ? PTR_W'(w_sum - SW'(MAX_DELAY))
                  : PTR_W'(w_sum);

  sample_ram #(
    .WIDTH (WIDTH),
    .DEPTH (MAX_DELAY),
    .AW    (PTR_W)
  ) u_ram (
    .clk     (clk),
    .i_we    (bus.in_valid),
    .i_waddr (r_wr_ptr),
    .i_wdata (bus.in_data),
    .i_re    (bus.in_valid),
    .i_raddr (w_rd_ptr),
    .o_rdata (w_ram_q)
  );

  always_comb begin
    w_state_nx = r_state;
    w_fill_nx  = r_fill_cnt;
    w_cur_nx   = r_cur_delay;
    w_wr_nx    = r_wr_ptr;
    w_ov_nx    = 1'b0;
    w_sel_nx   = r_out_sel;
    if (bus.in_valid) begin
      w_wr_nx = (r_wr_ptr == PTR_W'(MAX_DELAY - 1))
              ? '0 : r_wr_ptr + 1'b1;
    end
    if (bus.cfg_load) begin
      w_cur_nx = DLY_W'(clamp_delay(
        32'(bus.delay_cfg), MAX_DELAY));
      w_state_nx = FILL;
      w_fill_nx  = bus.in_valid ? DLY_W'(1) : '0;
      if (bus.in_valid) w_sel_nx = 1'b0;
    end else if (bus.in_valid) begin
      unique case (r_state)
        FILL: begin
          if (r_fill_cnt == r_cur_delay) begin
            w_state_nx = RUN;
            w_ov_nx    = 1'b1;
            w_sel_nx   = 1'b1;
          end else begin
            w_fill_nx = r_fill_cnt + 1'b1;
            w_sel_nx  = 1'b0;
          end
        end
        RUN: begin
          w_ov_nx  = 1'b1;
          w_sel_nx = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= FILL;
      r_fill_cnt  <= '0;
      r_cur_delay <= DLY_W'(DEFAULT_DELAY);
      r_wr_ptr    <= '0;
      r_out_valid <= 1'b0;
      r_out_sel   <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_fill_cnt  <= w_fill_nx;
      r_cur_delay <= w_cur_nx;
      r_wr_ptr    <= w_wr_nx;
      r_out_valid <= w_ov_nx;
      r_out_sel   <= w_sel_nx;
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_sel ? w_ram_q : '0;
  assign bus.filling   = (r_state == FILL);
  assign bus.cur_delay = r_cur_delay;
endmodule
